keccak_squeeze_unit: RTL and testbench

// Downstream of absorb/permutation: streams digest/XOF bytes from permuted Keccak state as DWIDTH-bit beats.

---
 rtl/keccak_squeeze_unit_if.sv | 15 +
 rtl/keccak_squeeze_unit.sv | 155 +++++++++++++++
 tb/tb_keccak_squeeze_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_squeeze_unit_if.sv
// Output byte stream of the Keccak squeeze unit: data, byte keep, last and valid/ready.
interface keccak_squeeze_unit_if #(
  parameter int unsigned DWIDTH = 256
);
  localparam int unsigned KeepWidth = DWIDTH / 8;

  logic [DWIDTH-1:0]    t_data;
  logic [KeepWidth-1:0] t_keep;
  logic                 t_last;
  logic                 t_valid;
  logic                 t_ready;

  modport master (output t_data, output t_keep, output t_last, output t_valid, input t_ready);
  modport slave  (input t_data, input t_keep, input t_last, input t_valid, output t_ready);
endinterface

// File: rtl/keccak_squeeze_unit.sv
// Streams digest/XOF bytes from a permuted Keccak state, requesting a permutation per rate block.
// Define KECCAK_SQUEEZE_XOF_EN for unbounded output (out_len_i == 0) terminated by stop_i.
module keccak_squeeze_unit #(
  parameter int unsigned DWIDTH        = 256,
  parameter int unsigned OUT_LEN_WIDTH = 32,
  parameter int unsigned RATE_WIDTH    = 11
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [RATE_WIDTH-1:0]         rate_i,
  input  logic [OUT_LEN_WIDTH-1:0]      out_len_i,
  input  logic [4:0][4:0][63:0]         state_array_i,
  output logic                          perm_req_o,
  input  logic                          perm_done_i,
  input  logic                          stop_i,
  keccak_squeeze_unit_if.master         tx,
  output logic                          busy_o,
  output logic                          done_o
);
  localparam int unsigned KeepWidth = DWIDTH / 8;
  localparam int unsigned LaneSize  = 64;
  localparam int unsigned RowSize   = 5;
  localparam int unsigned NumLanes  = 25;
  localparam int unsigned BeatLanes = DWIDTH / LaneSize;
  localparam int unsigned ByteWidth = RATE_WIDTH - 3;

  typedef enum logic [1:0] {StIdle, StEmit, StPerm, StDone} state_e;

  state_e                       st_q, st_d;
  logic [4:0][4:0][63:0]        lanes_q, lanes_d;
  logic [ByteWidth-1:0]         rate_bytes_q, rate_bytes_d;
  logic [ByteWidth-1:0]         offset_q, offset_d;
  logic [OUT_LEN_WIDTH-1:0]     remaining_q, remaining_d;
  logic                         unbounded_q, unbounded_d;
  logic                         stop_seen_q, stop_seen_d;
  logic                         stop_in, stop_req;
  logic [31:0]                  beat_n, rate_left, lane_k;
  logic [2:0]                   lane_x, lane_y;
  logic [DWIDTH-1:0]            beat_data;
  logic [KeepWidth-1:0]         beat_keep;
  logic                         beat_last, accept;
  logic [2:0]                   unused_rate_lsb;

`ifdef KECCAK_SQUEEZE_XOF_EN
  localparam bit XofEn = 1'b1;
  assign stop_in = stop_i;
`else
  localparam bit XofEn = 1'b0;
  logic unused_stop;
  assign unused_stop = stop_i;
  assign stop_in     = 1'b0;
`endif

  assign unused_rate_lsb = rate_i[2:0];
  assign stop_req        = stop_in | stop_seen_q;

  // Beat size is bounded by the beat width, the rest of the rate block and the request.
  always_comb begin
    rate_left = 32'(rate_bytes_q) - 32'(offset_q);
    beat_n    = 32'(KeepWidth);
    if (rate_left < beat_n) beat_n = rate_left;
    if (!unbounded_q && (32'(remaining_q) < beat_n)) beat_n = 32'(remaining_q);
  end

  assign beat_last = !unbounded_q && (beat_n == 32'(remaining_q));

  always_comb begin
    beat_data = '0;
    lane_k    = '0;
    lane_x    = '0;
    lane_y    = '0;
    for (int unsigned i = 0; i < BeatLanes; i++) begin
      lane_k = 32'(offset_q >> 3) + i;
      lane_x = 3'(lane_k % RowSize);
      lane_y = 3'(lane_k / RowSize);
      if (lane_k < NumLanes) beat_data[i*LaneSize +: LaneSize] = lanes_q[lane_x][lane_y];
    end
    for (int unsigned b = 0; b < KeepWidth; b++) begin
      beat_keep[b] = (b < beat_n);
      if (!beat_keep[b]) beat_data[8*b +: 8] = 8'h00;
    end
  end

  assign accept     = (st_q == StEmit) && tx.t_ready;
  assign tx.t_valid = (st_q == StEmit);
  assign tx.t_data  = tx.t_valid ? beat_data : '0;
  assign tx.t_keep  = tx.t_valid ? beat_keep : '0;
  assign tx.t_last  = tx.t_valid & beat_last;
  assign perm_req_o = (st_q == StPerm);
  assign busy_o     = (st_q != StIdle);
  assign done_o     = (st_q == StDone);

  always_comb begin
    st_d         = st_q;
    lanes_d      = lanes_q;
    rate_bytes_d = rate_bytes_q;
    offset_d     = offset_q;
    remaining_d  = remaining_q;
    unbounded_d  = unbounded_q;
    // A stop seen while a beat is pending is remembered until that beat is accepted.
    stop_seen_d  = ((st_q == StEmit) || (st_q == StPerm)) ? (stop_seen_q | stop_in) : 1'b0;
    unique case (st_q)
      StIdle: begin
        if (start_i) begin
          lanes_d      = state_array_i;
          rate_bytes_d = rate_i[RATE_WIDTH-1:3];
          remaining_d  = out_len_i;
          offset_d     = '0;
          unbounded_d  = XofEn && (out_len_i == '0);
          st_d         = ((out_len_i == '0) && !XofEn) ? StDone : StEmit;
        end
      end
      StEmit: begin
        if (accept) begin
          offset_d = offset_q + ByteWidth'(beat_n);
          if (!unbounded_q) remaining_d = remaining_q - OUT_LEN_WIDTH'(beat_n);
          if (beat_last || stop_req)        st_d = StDone;
          else if (offset_d == rate_bytes_q) st_d = StPerm;
        end
      end
      StPerm: begin
        if (stop_req) begin
          st_d = StDone;
        end else if (perm_done_i) begin
          lanes_d  = state_array_i;
          offset_d = '0;
          st_d     = StEmit;
        end
      end
      StDone:  st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q         <= StIdle;
      lanes_q      <= '0;
      rate_bytes_q <= '0;
      offset_q     <= '0;
      remaining_q  <= '0;
      unbounded_q  <= 1'b0;
      stop_seen_q  <= 1'b0;
    end else begin
      st_q         <= st_d;
      lanes_q      <= lanes_d;
      rate_bytes_q <= rate_bytes_d;
      offset_q     <= offset_d;
      remaining_q  <= remaining_d;
      unbounded_q  <= unbounded_d;
      stop_seen_q  <= stop_seen_d;
    end
  end
endmodule

// File: tb/tb_keccak_squeeze_unit.sv
// Directed bench for keccak_squeeze_unit: fixed-length digests, rate tails, backpressure, reset.
module tb_keccak_squeeze_unit;
  localparam int unsigned DW = 256;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  perm_done = 1'b0;
  logic                  stop = 1'b0;
  logic [10:0]           rate = '0;
  logic [31:0]           out_len = '0;
  logic [4:0][4:0][63:0] st = '0;
  logic                  perm_req, busy, done;
  int                    n_checks = 0;
  int                    n_fail = 0;

  keccak_squeeze_unit_if #(.DWIDTH(DW)) tx_if ();

  keccak_squeeze_unit #(.DWIDTH(DW), .OUT_LEN_WIDTH(32), .RATE_WIDTH(11)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .rate_i        (rate),
    .out_len_i     (out_len),
    .state_array_i (st),
    .perm_req_o    (perm_req),
    .perm_done_i   (perm_done),
    .stop_i        (stop),
    .tx            (tx_if),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte j of lane k is (8k+j) ^ m, so the linear byte stream is just (offset+b) ^ m.
  function automatic logic [4:0][4:0][63:0] make_state(input logic [7:0] m);
    logic [4:0][4:0][63:0] s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int j = 0; j < 8; j++) s[x][y][8*j +: 8] = 8'((x + 5*y)*8 + j) ^ m;
    return s;
  endfunction

  function automatic logic [255:0] exp_data(input int off, input int n, input logic [7:0] m);
    logic [255:0] d = '0;
    for (int b = 0; b < n; b++) d[8*b +: 8] = 8'(off + b) ^ m;
    return d;
  endfunction

  function automatic logic [31:0] exp_keep(input int n);
    logic [31:0] k = '0;
    for (int b = 0; b < n; b++) k[b] = 1'b1;
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [10:0] r, input logic [31:0] len, input logic [7:0] m);
    rate    = r;
    out_len = len;
    st      = make_state(m);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic check_beat(input string tag, input int off, input int n, input logic [7:0] m,
                            input logic last);
    check_eq({tag, " valid"}, 256'(tx_if.t_valid), 256'(1'b1));
    check_eq({tag, " keep"}, 256'(tx_if.t_keep), 256'(exp_keep(n)));
    check_eq({tag, " data"}, tx_if.t_data, exp_data(off, n, m));
    check_eq({tag, " last"}, 256'(tx_if.t_last), 256'(last));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " valid"}, 256'(tx_if.t_valid), 256'(0));
    check_eq({tag, " last"}, 256'(tx_if.t_last), 256'(0));
    check_eq({tag, " data"}, tx_if.t_data, 256'(0));
    check_eq({tag, " keep"}, 256'(tx_if.t_keep), 256'(0));
    check_eq({tag, " perm_req"}, 256'(perm_req), 256'(0));
    check_eq({tag, " busy"}, 256'(busy), 256'(0));
    check_eq({tag, " done"}, 256'(done), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]  ready_pat;
    logic         stall;
    logic [255:0] held_data;
    logic [31:0]  held_keep;
    logic         held_last;
    int           beats;

    tx_if.t_ready = 1'b1;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // SHA3-256: one full beat, lanes 0..3.
    do_start(11'd1088, 32'd32, 8'h00);
    check_beat("sha256", 0, 32, 8'h00, 1'b1);
    check_eq("sha256 busy", 256'(busy), 256'(1));
    tick();
    check_eq("sha256 done", 256'(done), 256'(1));
    check_eq("sha256 valid after", 256'(tx_if.t_valid), 256'(0));
    tick();
    check_eq("sha256 done clear", 256'(done), 256'(0));

    // SHA3-224: short beat; a start while busy must be ignored.
    do_start(11'd1152, 32'd28, 8'h00);
    check_beat("sha224", 0, 28, 8'h00, 1'b1);
    rate = 11'd1344; out_len = 32'd200; start = 1'b1;
    tick();
    check_eq("sha224 done", 256'(done), 256'(1));
    tick();
    start = 1'b0;
    check_eq("sha224 start ignored", 256'(busy), 256'(0));

    // SHAKE128, 200 bytes: five full beats, 8-byte rate tail, permutation, final beat.
    do_start(11'd1344, 32'd200, 8'h00);
    for (int i = 0; i < 5; i++) begin
      check_beat($sformatf("shake128 b%0d", i), 32*i, 32, 8'h00, 1'b0);
      tick();
    end
    check_beat("shake128 tail", 160, 8, 8'h00, 1'b0);
    tick();
    check_eq("shake128 perm_req", 256'(perm_req), 256'(1));
    check_eq("shake128 no valid in perm", 256'(tx_if.t_valid), 256'(0));
    st = make_state(8'hFF);
    perm_done = 1'b1;
    tick();
    perm_done = 1'b0;
    check_eq("shake128 perm_req drop", 256'(perm_req), 256'(0));
    check_beat("shake128 final", 0, 32, 8'hFF, 1'b1);
    tick();
    check_eq("shake128 done", 256'(done), 256'(1));
    tick();

    // SHAKE256 with backpressure: held beat must not change while stalled.
    ready_pat = 16'b1011_0010_1000_0110;
    beats = 0;
    stall = 1'b0;
    held_data = '0; held_keep = '0; held_last = 1'b0;
    tx_if.t_ready = 1'b0;
    do_start(11'd1088, 32'd96, 8'h00);
    for (int c = 0; c < 64 && beats < 3; c++) begin
      if (stall) begin
        check_eq("bp data stable", tx_if.t_data, held_data);
        check_eq("bp keep stable", 256'(tx_if.t_keep), 256'(held_keep));
        check_eq("bp last stable", 256'(tx_if.t_last), 256'(held_last));
      end
      tx_if.t_ready = ready_pat[c % 16];
      stall = 1'b0;
      if (tx_if.t_valid) begin
        if (tx_if.t_ready) begin
          check_beat($sformatf("bp b%0d", beats), 32*beats, 32, 8'h00, beats == 2);
          beats++;
        end else begin
          stall = 1'b1;
          held_data = tx_if.t_data; held_keep = tx_if.t_keep; held_last = tx_if.t_last;
        end
      end
      tick();
    end
    check_eq("bp beat count", 256'(beats), 256'(3));
    check_eq("bp done", 256'(done), 256'(1));
    tx_if.t_ready = 1'b1;
    tick();

    // Asynchronous reset during beat 2 of 4, then a clean restart.
    do_start(11'd1088, 32'd128, 8'h00);
    check_beat("rst b0", 0, 32, 8'h00, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst mid");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("rst no partial beat", 256'(tx_if.t_valid), 256'(0));
    do_start(11'd1088, 32'd64, 8'h00);
    check_beat("restart b0", 0, 32, 8'h00, 1'b0);
    tick();
    check_beat("restart b1", 32, 32, 8'h00, 1'b1);
    tick();
    check_eq("restart done", 256'(done), 256'(1));
    tick();

`ifdef KECCAK_SQUEEZE_XOF_EN
    // Unbounded SHAKE128, stopped on the 7th beat.
    do_start(11'd1344, 32'd0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      check_beat($sformatf("xof b%0d", i), 32*i, 32, 8'h00, 1'b0);
      tick();
    end
    check_beat("xof tail", 160, 8, 8'h00, 1'b0);
    tick();
    check_eq("xof perm_req", 256'(perm_req), 256'(1));
    st = make_state(8'hFF);
    perm_done = 1'b1;
    tick();
    perm_done = 1'b0;
    check_beat("xof b6", 0, 32, 8'hFF, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("xof done", 256'(done), 256'(1));
    check_eq("xof valid after stop", 256'(tx_if.t_valid), 256'(0));
    tick();
`else
    // Empty request: straight to done, no beats.
    do_start(11'd1088, 32'd0, 8'h00);
    check_eq("empty valid", 256'(tx_if.t_valid), 256'(0));
    check_eq("empty done", 256'(done), 256'(1));
    tick();
    check_eq("empty done clear", 256'(done), 256'(0));
    check_eq("empty busy", 256'(busy), 256'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
